// File: rtl/compare_4_core.sv
// compare_4_core: registered 4-bit magnitude comparator stage with cascade input and invalid-cascade flag
module compare_4_core (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [3:0] iData_a,
  input  logic [3:0] iData_b,
  input  logic [2:0] iData,
  output logic [2:0] oData,
  output logic       oErr
);
  logic [2:0] data_d, data_q;
  logic       err_d, err_q;
  // next result: operands decide unless equal, then equal-in dominates the cascade code
  always_comb begin
    data_d = (iData_a > iData_b) ? 3'b100 :
             (iData_a < iData_b) ? 3'b010 :
             iData[0]            ? 3'b001 :
             (iData == 3'b100)   ? 3'b100 :
             (iData == 3'b010)   ? 3'b010 : 3'b001;
    err_d  = (iData[2] & iData[1]) | (iData[2] & iData[0]) | (iData[1] & iData[0]);
  end
  // result registers; reset forces the equal code so the output stays one-hot
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      data_q <= 3'b001;
      err_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      err_q  <= err_d;
    end
  assign oData = data_q;
  assign oErr  = err_q;
endmodule

// File: tb/tb_compare_4_core.sv
// tb_compare_4_core: randomized and exhaustive checking of compare_4_core against a behavioural model
module tb_compare_4_core;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0, b = '0;
  logic [2:0] c = '0;
  logic [2:0] o_data;
  logic       o_err;
  logic [2:0] exp_data;
  logic       exp_err;
  logic       run = 1'b0;
  int n_chk = 0, n_fail = 0;

  compare_4_core dut (
    .iClk(clk), .iRst(rst), .iData_a(a), .iData_b(b), .iData(c),
    .oData(o_data), .oErr(o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model(int ia, int ib, logic [2:0] ic);
    int ones;
    logic [2:0] r;
    ones = ic[0] + ic[1] + ic[2];
    if (ia > ib) r = 3'b100;
    else if (ia < ib) r = 3'b010;
    else if (ic[0]) r = 3'b001;
    else if (ic == 3'b100) r = 3'b100;
    else if (ic == 3'b010) r = 3'b010;
    else r = 3'b001;
    return {r, ones > 1};
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) {exp_data, exp_err} <= 4'b0010;
    else {exp_data, exp_err} <= model(int'(a), int'(b), c);

  task automatic check(string name, logic [3:0] act, logic [3:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got data=%b err=%b, expected data=%b err=%b",
               name, act[3:1], act[0], req[3:1], req[0]);
    end
  endtask

  always @(negedge clk)
    if (run) check("model", {o_data, o_err}, {exp_data, exp_err});

  task automatic step(logic [3:0] ia, logic [3:0] ib, logic [2:0] ic);
    @(negedge clk);
    #1;
    a = ia; b = ib; c = ic;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("reset_hold", {o_data, o_err}, 4'b0010);
    @(negedge clk);
    #1 rst = 1'b0;
    run = 1'b1;
    step(4'b0000, 4'b0000, 3'b000); check("eq_nocascade", {o_data, o_err}, 4'b0010);
    step(4'b0001, 4'b0010, 3'b001); check("less", {o_data, o_err}, 4'b0100);
    step(4'b0010, 4'b0001, 3'b010); check("greater", {o_data, o_err}, 4'b1000);
    step(4'b1010, 4'b1010, 3'b100); check("pass_gt", {o_data, o_err}, 4'b1000);
    step(4'b1010, 4'b1010, 3'b010); check("pass_lt", {o_data, o_err}, 4'b0100);
    step(4'b0111, 4'b0111, 3'b110); check("bad_cascade_eq", {o_data, o_err}, 4'b0011);
    step(4'b1111, 4'b0000, 3'b011); check("bad_cascade_gt", {o_data, o_err}, 4'b1001);
    step(4'b0101, 4'b0101, 3'b111); check("all_ones_eq", {o_data, o_err}, 4'b0011);
    step(4'b1111, 4'b0000, 3'b000);
    #1 rst = 1'b1;
    #1 check("async_reset", {o_data, o_err}, 4'b0010);
    @(negedge clk);
    #1;
    rst = 1'b0;
    a = 4'b0011; b = 4'b1100; c = 3'b101;
    @(posedge clk);
    #1 check("post_reset", {o_data, o_err}, 4'b0101);
    for (int i = 0; i < 2048; i++) begin
      logic [10:0] v;
      v = i[10:0];
      step(v[10:7], v[6:3], v[2:0]);
    end
    for (int i = 0; i < 300; i++)
      step(4'($urandom_range(15)), 4'($urandom_range(15)), 3'($urandom_range(7)));
    @(negedge clk);
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
